cpu_step_ctrl: RTL and testbench
================================

// Module: cpu_step_ctrl
// PURPOSE
//  Multi-cycle sequencer for the board-level CPU datapath behind Top. Turns a raw
//  manual-step button into clean one-cycle ticks (or free-runs). Walks an FSM
//  FETCH/DECODE/EXEC/MEM/WB. Issues single-cycle write enables and level mux selects.
//  Exposes state and a retired-instruction count for the SW-selected LED display.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive equal synced samples before button level is accepted
//  CNT_W            8   width of retired-instruction counter (wraps)
// PORTS
//  Clk        in   1      system clock; all state on rising edge
//  Rst        in   1      asynchronous, active-low reset
//  Step       in   1      raw (bouncy, asynchronous) manual-step button, active-high
//  Run        in   1      1 = tick every cycle, 0 = tick per debounced Step press
//  Op         in   3      opcode from IR: 0 ADD,1 SUB,2 AND,3 OR,4 LW,5 SW,6 BEQ,7 J
//  Zero       in   1      ALU zero flag, valid in EXEC
//  PC_Wr      out  1      one-cycle PC load enable
//  PC_Src     out  2      0 PC+1, 1 branch target, 2 jump target (level)
//  IR_Wr      out  1      one-cycle instruction-register load
//  ALU_Op     out  2      0 add,1 sub,2 and,3 or (level)
//  Mem_Rd     out  1      one-cycle data-memory read strobe
//  Mem_Wr     out  1      one-cycle data-memory write strobe
//  Reg_Wr     out  1      one-cycle register-file write
//  State      out  3      current FSM state code
//  Instr_Cnt  out  CNT_W  retired instructions, mod 2^CNT_W
// BEHAVIOUR
//  Reset (Rst=0, async): State=IDLE, Instr_Cnt=0, every strobe 0, PC_Src=0, ALU_Op=0.
//  Reset also clears the sync/debounce path. Release is sampled on the next Clk edge.
//  Mid-operation reset aborts the instruction; no strobe fires in the assertion cycle.
//  Step path: 2-flop sync, then debounce counter. Debounced level rises after
//   DEBOUNCE_CYCLES consecutive high synced samples; a rising edge gives a 1-cycle pulse.
//   Any mismatching sample restarts the count. One press gives exactly one pulse.
//   Holding Step high gives no repeat pulses.
//  Run is 2-flop synced only. tick = Run_sync | step_pulse.
//   Switching Run 1->0 stops after the current tick.
//  States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5. The FSM moves only on a tick.
//   Strobes are asserted combinationally as (tick & state & cond), so each is high
//   for at most 1 cycle per tick.
//   IDLE   -> FETCH   no strobes
//   FETCH  -> DECODE  IR_Wr=1, PC_Wr=1, PC_Src=0
//   DECODE -> FETCH if Op=J: PC_Wr=1, PC_Src=2, Instr_Cnt++; otherwise -> EXEC
//   EXEC   -> WB (Op 0-3) | MEM (Op 4,5)
//          -> FETCH if Op=BEQ: PC_Wr=Zero, PC_Src=1, Instr_Cnt++
//   MEM    -> WB if LW: Mem_Rd=1; -> FETCH if SW: Mem_Wr=1, Instr_Cnt++
//   WB     -> FETCH   Reg_Wr=1, Instr_Cnt++
//  ALU_Op: EXEC/WB take Op[1:0] for Op 0-3; BEQ=sub; LW/SW=add. All other states: 0.
//  Instr_Cnt wraps 2^CNT_W-1 -> 0.
//  Op is sampled only when ticked in DECODE/EXEC/MEM; Op changes between ticks are legal.
//  Unused state codes 6,7 -> IDLE on the next Clk edge with no strobes.
// STRUCTURE
//  Package cpu_ctrl_pkg: state codes, opcode constants, ALU_Op and PC_Src encodings.
//  Sub-module btn_debounce (sync + debounce + edge pulse), parameterised on DEBOUNCE_CYCLES.
//  Top level holds the FSM, strobe decode and counter.
// TESTING
//  1 Reset, Run=0, clean Step press held 20 cycles -> exactly 1 tick.
//    Pulse lands 2+DEBOUNCE_CYCLES cycles after the first high sample; State 0->1.
//  2 Step bouncing 1,0,1,0 every cycle then stable high -> one pulse, timed from last
//    rising bounce; no pulse on bounce edges.
//  3 Run=1, Op=ADD -> State 1,2,3,5,1.
//    IR_Wr+PC_Wr in FETCH, Reg_Wr in WB; each 1 cycle; Instr_Cnt 0->1.
//  4 Run=1: LW -> Mem_Rd, Reg_Wr. SW -> Mem_Wr, no Reg_Wr.
//    BEQ Zero=1 -> PC_Wr, PC_Src=1. BEQ Zero=0 -> no PC_Wr in EXEC.
//    J -> PC_Src=2 from DECODE.
//  5 Run=1 ADD loop for 256 instructions -> Instr_Cnt wraps 255->0.
//  6 Rst=0 asserted mid-EXEC (async, between edges) -> State=0, Instr_Cnt=0 and strobes 0
//    immediately. After release, first tick -> FETCH.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU step controller: FSM state codes,
// opcodes, ALU operation and PC source selects.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_BEQ = 3'd6;
    localparam logic [2:0] OP_J   = 3'd7;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    localparam logic [1:0] PC_SRC_INC    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    // R-type opcodes map straight onto the ALU encoding; BEQ compares by
    // subtraction; loads/stores compute an address with an add.
    function automatic logic [1:0] alu_for_op(input logic [2:0] op);
        logic [1:0] res;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: res = op[1:0];
            OP_BEQ:                        res = ALU_SUB;
            default:                       res = ALU_ADD;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Manual-step button conditioner: two-flop synchroniser, consecutive-sample
// debounce counter, and a one-cycle pulse on each accepted rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          level_d_reg;
    logic          pulse_reg;
    logic [CW-1:0] cnt_reg;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples;
    // a sample equal to the current level restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_reg <= 1'b0;
            cnt_reg   <= '0;
        end else if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    // Registered rising-edge detect so a held button yields a single pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d_reg <= 1'b0;
            pulse_reg   <= 1'b0;
        end else begin
            level_d_reg <= level_reg;
            pulse_reg   <= level_reg & ~level_d_reg;
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB walked one step per tick,
// where a tick is either free-run (run) or a debounced manual step press.
// Strobes are tick-qualified so each fires for exactly one cycle per step.
module cpu_step_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             run,
    input  logic [2:0]       op,
    input  logic             zero,
    output logic             pc_wr,
    output logic [1:0]       pc_src,
    output logic             ir_wr,
    output logic [1:0]       alu_op,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             reg_wr,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] instr_cnt_reg;
    logic             retire;
    logic             illegal;
    logic             run_sync1_reg;
    logic             run_sync2_reg;
    logic             step_pulse;
    logic             tick;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (step),
        .pulse (step_pulse)
    );

    // Run is a level switch; it only needs synchronising, not debouncing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_sync1_reg <= 1'b0;
            run_sync2_reg <= 1'b0;
        end else begin
            run_sync1_reg <= run;
            run_sync2_reg <= run_sync1_reg;
        end
    end

    assign tick = run_sync2_reg | step_pulse;

    // Next-state, strobe and select decode for the current state and opcode.
    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        illegal    = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_src     = PC_SRC_INC;
        alu_op     = ALU_ADD;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_wr     = 1'b0;
        case (state_reg)
            ST_IDLE: state_next = ST_FETCH;
            ST_FETCH: begin
                ir_wr      = tick;
                pc_wr      = tick;
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (op == OP_J) begin
                    pc_src     = PC_SRC_JUMP;
                    pc_wr      = tick;
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op = alu_for_op(op);
                if (op == OP_BEQ) begin
                    pc_src     = PC_SRC_BRANCH;
                    pc_wr      = tick & zero;
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                end else if (op == OP_LW || op == OP_SW) begin
                    state_next = ST_MEM;
                end else if (op == OP_J) begin
                    // Jumps retire in DECODE; recover if op changed underneath.
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                mem_rd = tick & (op == OP_LW);
                mem_wr = tick & (op == OP_SW);
                if (op == OP_SW) begin
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_WB: begin
                alu_op     = alu_for_op(op);
                reg_wr     = tick;
                retire     = 1'b1;
                state_next = ST_FETCH;
            end
            default: begin
                illegal    = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    // State advances on a tick; unused codes fall back to IDLE unconditionally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            instr_cnt_reg <= '0;
        end else begin
            if (tick || illegal) begin
                state_reg <= state_next;
            end
            if (tick && retire) begin
                instr_cnt_reg <= instr_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign state     = state_reg;
    assign instr_cnt = instr_cnt_reg;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: a sample-window model of the step path plus an
// opcode-table model of the sequencer, compared every cycle, with directed
// scenarios carrying hand-computed expectations.
module tb_cpu_step_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n, step, run, zero;
    logic [2:0] op;
    logic       pc_wr, ir_wr, mem_rd, mem_wr, reg_wr;
    logic [1:0] pc_src, alu_op;
    logic [2:0] state;
    logic [7:0] instr_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_step_ctrl #(.DEBOUNCE_CYCLES(N), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .step(step), .run(run), .op(op), .zero(zero),
        .pc_wr(pc_wr), .pc_src(pc_src), .ir_wr(ir_wr), .alu_op(alu_op),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr),
        .state(state), .instr_cnt(instr_cnt)
    );

    // ---------------- behavioural model ----------------
    // m_sh[j] holds the step input seen at the edge j+1 edges ago; the
    // debounced level flips when the N synchronised samples (two edges late)
    // all disagree with it. The pulse follows one edge after the flip.
    logic [7:0] m_sh;
    logic       m_level, m_rose, m_pulse, m_run, m_run_h;
    logic [2:0] m_state;
    logic [7:0] m_cnt;
    wire        m_tick = m_run | m_pulse;

    function automatic logic win_all(input logic [7:0] sh, input logic v);
        logic r = 1'b1;
        for (int j = 1; j <= N; j++) if (sh[j] != v) r = 1'b0;
        return r;
    endfunction

    function automatic logic [2:0] m_next(input logic [2:0] s, input logic [2:0] o);
        case (s)
            3'd0: return 3'd1;
            3'd1: return 3'd2;
            3'd2: return (o == 3'd7) ? 3'd1 : 3'd3;
            3'd3: return (o < 3'd4) ? 3'd5 : (o == 3'd4 || o == 3'd5) ? 3'd4 : 3'd1;
            3'd4: return (o == 3'd5) ? 3'd1 : 3'd5;
            3'd5: return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic m_retires(input logic [2:0] s, input logic [2:0] o);
        return (s == 3'd2 && o == 3'd7) || (s == 3'd3 && o == 3'd6) ||
               (s == 3'd4 && o == 3'd5) || (s == 3'd5);
    endfunction

    // Expected {state, cnt, ir_wr, pc_wr, pc_src, alu_op, mem_rd, mem_wr, reg_wr}.
    function automatic logic [19:0] m_outputs(input logic [2:0] s, input logic [7:0] c,
                                              input logic t, input logic [2:0] o, input logic z);
        logic       e_ir, e_pcwr, e_rd, e_wr, e_rw;
        logic [1:0] e_src, e_alu;
        e_ir   = t && s == 3'd1;
        e_pcwr = t && (s == 3'd1 || (s == 3'd2 && o == 3'd7) || (s == 3'd3 && o == 3'd6 && z));
        e_src  = (s == 3'd2 && o == 3'd7) ? 2'd2 : (s == 3'd3 && o == 3'd6) ? 2'd1 : 2'd0;
        e_alu  = 2'd0;
        if (s == 3'd3 || s == 3'd5) e_alu = (o < 3'd4) ? o[1:0] : (o == 3'd6) ? 2'd1 : 2'd0;
        e_rd   = t && s == 3'd4 && o == 3'd4;
        e_wr   = t && s == 3'd4 && o == 3'd5;
        e_rw   = t && s == 3'd5;
        return {s, c, e_ir, e_pcwr, e_src, e_alu, e_rd, e_wr, e_rw};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sh <= '0; m_level <= 1'b0; m_rose <= 1'b0; m_pulse <= 1'b0;
            m_run <= 1'b0; m_run_h <= 1'b0; m_state <= 3'd0; m_cnt <= 8'd0;
        end else begin
            if (m_state > 3'd5) begin
                m_state <= 3'd0;
            end else if (m_tick) begin
                m_state <= m_next(m_state, op);
                if (m_retires(m_state, op)) m_cnt <= m_cnt + 8'd1;
            end
            m_rose <= !m_level && win_all(m_sh, 1'b1);
            if (!m_level && win_all(m_sh, 1'b1)) m_level <= 1'b1;
            else if (m_level && win_all(m_sh, 1'b0)) m_level <= 1'b0;
            m_pulse <= m_rose;
            m_sh    <= {m_sh[6:0], step};
            m_run_h <= run;
            m_run   <= m_run_h;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic wait_state(input int s, input int lim, input string name);
        int k = 0;
        while (state != 3'(s) && k < lim) begin
            cyc(1);
            k++;
        end
        chk(name, int'(state), s);
    endtask

    logic f_rd, f_wr, f_rw, f_pc_exec, f_br, f_jmp;

    // Launch one instruction from FETCH (run=1) and collect the strobes seen.
    task automatic run_instr(input logic [2:0] o, input logic z);
        int k;
        logic [7:0] c1;
        wait_state(1, 12, "fetch_wait");
        op = o; zero = z;
        #1;
        c1 = instr_cnt + 8'd1;
        f_rd = 0; f_wr = 0; f_rw = 0; f_pc_exec = 0; f_br = 0; f_jmp = 0;
        k = 0;
        do begin
            f_rd      |= mem_rd;
            f_wr      |= mem_wr;
            f_rw      |= reg_wr;
            f_pc_exec |= pc_wr && state == 3'd3;
            f_br      |= pc_wr && pc_src == 2'd1;
            f_jmp     |= pc_wr && pc_src == 2'd2 && state == 3'd2;
            cyc(1);
            k++;
        end while (state != 3'd1 && k < 10);
        chk("instr_done", int'(state), 1);
        chk("retire_cnt", int'(instr_cnt), int'(c1));
    endtask

    // ---------------- compare + stimulus ----------------
    initial begin
        fork
            begin : compare
                logic [19:0] exp_v, act_v;
                forever begin
                    @(negedge clk);
                    exp_v = m_outputs(m_state, m_cnt, m_tick, op, zero);
                    act_v = {state, instr_cnt, ir_wr, pc_wr, pc_src, alu_op, mem_rd, mem_wr, reg_wr};
                    checks++;
                    if (act_v !== exp_v) begin
                        errors++;
                        $display("FAIL cycle_cmp @%0t: got %05h expected %05h", $time, act_v, exp_v);
                    end
                end
            end
            begin : stimulus
                rst_n = 1'b1; step = 1'b0; run = 1'b0; op = 3'd0; zero = 1'b0;
                #1 rst_n = 1'b0;
                cyc(3);
                chk("rst_state", int'(state), 0);
                chk("rst_cnt", int'(instr_cnt), 0);
                chk("rst_strobes", int'({ir_wr, pc_wr, mem_rd, mem_wr, reg_wr}), 0);
                rst_n = 1'b1;
                cyc(2);

                // 1: clean press held 20 cycles -> one tick, 2+N edges after first sample
                step = 1'b1;
                cyc(7);
                chk("t1_before_tick", int'(state), 0);
                cyc(1);
                chk("t1_tick", int'(state), 1);
                cyc(12);
                chk("t1_held_no_repeat", int'(state), 1);
                step = 1'b0;
                cyc(10);
                chk("t1_release", int'(state), 1);

                // 2: bouncing press; single pulse timed from the last rising bounce
                step = 1'b1; cyc(1); step = 1'b0; cyc(1);
                step = 1'b1; cyc(1); step = 1'b0; cyc(1);
                step = 1'b1;
                cyc(7);
                chk("t2_no_bounce_pulse", int'(state), 1);
                cyc(1);
                chk("t2_tick", int'(state), 2);
                cyc(12);
                chk("t2_held", int'(state), 2);
                step = 1'b0;
                cyc(10);

                // 3: free-run ADD: 1,2,3,5,1 and one retire
                rst_n = 1'b0; run = 1'b1; op = 3'd0;
                cyc(2);
                rst_n = 1'b1;
                wait_state(1, 10, "t3_fetch");
                chk("t3_fetch_irwr", int'(ir_wr), 1);
                chk("t3_cnt0", int'(instr_cnt), 0);
                cyc(1); chk("t3_decode", int'(state), 2);
                cyc(1); chk("t3_exec", int'(state), 3);
                cyc(1); chk("t3_wb", int'(state), 5);
                chk("t3_regwr", int'(reg_wr), 1);
                cyc(1); chk("t3_back_fetch", int'(state), 1);
                chk("t3_cnt1", int'(instr_cnt), 1);

                // 4: per-opcode strobes
                run_instr(3'd4, 1'b0);
                chk("lw_memrd", int'(f_rd), 1);
                chk("lw_regwr", int'(f_rw), 1);
                chk("lw_no_memwr", int'(f_wr), 0);
                run_instr(3'd5, 1'b0);
                chk("sw_memwr", int'(f_wr), 1);
                chk("sw_no_regwr", int'(f_rw), 0);
                run_instr(3'd6, 1'b1);
                chk("beq_taken_pcwr", int'(f_br), 1);
                run_instr(3'd6, 1'b0);
                chk("beq_not_taken", int'(f_pc_exec), 0);
                run_instr(3'd7, 1'b0);
                chk("j_pcsrc2", int'(f_jmp), 1);
                chk("j_no_regwr", int'(f_rw), 0);
                run_instr(3'd3, 1'b0);
                chk("or_regwr", int'(f_rw), 1);

                // 5: counter wrap
                rst_n = 1'b0;
                cyc(2);
                rst_n = 1'b1;
                for (int i = 0; i < 255; i++) run_instr(3'd0, 1'b0);
                chk("t5_cnt255", int'(instr_cnt), 255);
                run_instr(3'd0, 1'b0);
                chk("t5_wrap", int'(instr_cnt), 0);

                // 6: async reset in the middle of EXEC
                run_instr(3'd0, 1'b0);
                chk("t6_cnt1", int'(instr_cnt), 1);
                op = 3'd4;
                wait_state(3, 6, "t6_exec");
                rst_n = 1'b0;
                #1;
                chk("t6_state", int'(state), 0);
                chk("t6_cnt", int'(instr_cnt), 0);
                chk("t6_strobes", int'({ir_wr, pc_wr, mem_rd, mem_wr, reg_wr}), 0);
                chk("t6_selects", int'({pc_src, alu_op}), 0);
                cyc(2);
                rst_n = 1'b1;
                begin
                    int k = 0;
                    while (state == 3'd0 && k < 10) begin
                        cyc(1);
                        k++;
                    end
                end
                chk("t6_first_tick_fetch", int'(state), 1);
                run = 1'b0;
                cyc(6);
            end
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
